// File: rtl/lcd_lock_monitor.sv
// rtl/lcd_lock_monitor.sv - LCD PLL lock supervisor: filtered lock, PLL retry reset, pixel-logic reset
module lcd_lock_monitor #(
    parameter int LOCK_FILT   = 1024,
    parameter int RST_HOLD    = 16,
    parameter int TIMEOUT     = 65536,
    parameter int RESET_PULSE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lock_in,
    input  logic       clr_cnt,
    output logic       pll_reset,
    output logic       lcd_rst_n,
    output logic       locked,
    output logic [2:0] state,
    output logic [7:0] loss_cnt,
    output logic [7:0] retry_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TW = $clog2(max2(max2(LOCK_FILT, RST_HOLD), max2(TIMEOUT, RESET_PULSE)) + 1);
    localparam logic [TW-1:0] FILT_LAST  = TW'(LOCK_FILT - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(RST_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(RESET_PULSE - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_FILTER    = 3'd1,
        S_HOLD      = 3'd2,
        S_RUN       = 3'd3,
        S_PLL_RST   = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_lock_s;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_pll_reset;
    logic          r_lcd_rst_n;
    logic          r_locked;
    logic [7:0]    r_loss_cnt;
    logic [7:0]    r_retry_cnt;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_loss_inc;
    logic          w_retry_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= lock_in;
            r_lock_s <= r_sync1;
        end
    end

    // One shared timer: WAIT_LOCK timeout, FILTER run length, HOLD length, PLL_RST pulse width.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TW'(1);
        w_loss_inc  = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            S_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = S_FILTER;
                    w_timer_nxt = '0;
                end else if (r_timer == TO_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_timer_nxt = '0;
                    w_retry_inc = 1'b1;
                end
            end
            S_FILTER: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == FILT_LAST) begin
                    w_state_nxt = S_HOLD;
                    w_timer_nxt = '0;
                end
            end
            S_HOLD: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                    w_loss_inc  = 1'b1;
                end else if (r_timer == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                end
            end
            S_RUN: begin
                w_timer_nxt = '0;
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_loss_inc  = 1'b1;
                end
            end
            S_PLL_RST: begin
                if (r_timer == PULSE_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_WAIT_LOCK;
            r_timer     <= '0;
            r_pll_reset <= 1'b0;
            r_lcd_rst_n <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_pll_reset <= (w_state_nxt == S_PLL_RST);
            r_lcd_rst_n <= (w_state_nxt == S_RUN);
            r_locked    <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt  <= 8'd0;
            r_retry_cnt <= 8'd0;
        end else if (clr_cnt) begin
            r_loss_cnt  <= 8'd0;
            r_retry_cnt <= 8'd0;
        end else begin
            if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
            if (w_retry_inc && (r_retry_cnt != 8'hFF)) begin
                r_retry_cnt <= r_retry_cnt + 8'd1;
            end
        end
    end

    assign pll_reset = r_pll_reset;
    assign lcd_rst_n = r_lcd_rst_n;
    assign locked    = r_locked;
    assign state     = r_state;
    assign loss_cnt  = r_loss_cnt;
    assign retry_cnt = r_retry_cnt;

endmodule

// File: doc/lcd_lock_monitor.md
LCD_LOCK_MONITOR -- requirements
Module: lcd_lock_monitor

Interface
REQ-001 Parameter LOCK_FILT, default 1024: consecutive synchronized lock-high cycles required before lock is declared.
REQ-002 Parameter RST_HOLD, default 16: cycles lcd_rst_n stays low after lock is declared.
REQ-003 Parameter TIMEOUT, default 65536: cycles waited for lock before a PLL reset is issued; legal range 2..2^20.
REQ-004 Parameter RESET_PULSE, default 8: width in cycles of the pll_reset pulse.
REQ-005 Port clk  input  1  reference clock (PLL input clock domain); the block's only clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port lock_in  input  1  PLL lock output, asynchronous to clk.
REQ-008 Port clr_cnt  input  1  synchronous clear of both event counters.
REQ-009 Port pll_reset  output  1  active-high reset to the LCD PLL.
REQ-010 Port lcd_rst_n  output  1  active-low reset for the LCD pixel-clock logic.
REQ-011 Port locked  output  1  filtered lock status.
REQ-012 Port state  output  3  current FSM state code.
REQ-013 Port loss_cnt  output  8  lock-loss event count, saturating.
REQ-014 Port retry_cnt  output  8  lock-timeout (PLL reset) count, saturating.

Function
REQ-015 lock_in SHALL pass through a 2-flop synchronizer; only the synchronized lock_s SHALL be used.
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states and codes SHALL be: WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3, PLL_RST=4; codes 5-7 SHALL recover to WAIT_LOCK.
REQ-018 WAIT_LOCK: timer increments each cycle; lock_s=1 -> FILTER, timer cleared; timer at TIMEOUT-1 with lock_s=0 -> PLL_RST, retry_cnt+1, timer cleared.
REQ-019 PLL_RST: pll_reset=1 for exactly RESET_PULSE cycles, then WAIT_LOCK with timer 0; lock_s SHALL be ignored in this state.
REQ-020 FILTER: lock_s=0 -> WAIT_LOCK, timer 0, no loss count; after LOCK_FILT consecutive FILTER cycles with lock_s=1 -> HOLD, locked=1.
REQ-021 HOLD: lcd_rst_n=0, locked=1; after RST_HOLD cycles -> RUN, lcd_rst_n=1.
REQ-022 RUN: lcd_rst_n=1, locked=1; lock_s=0 -> WAIT_LOCK.
REQ-023 lock_s=0 in HOLD or RUN -> WAIT_LOCK, locked=0, lcd_rst_n=0 on the same edge, loss_cnt+1.
REQ-024 Loss latency: lcd_rst_n and locked SHALL fall on the 3rd rising clk edge after lock_in falls (edge 1 samples).
REQ-025 Lock latency: locked SHALL rise on edge LOCK_FILT+3 after lock_in rises; lcd_rst_n SHALL rise RST_HOLD edges later.
REQ-026 Counters SHALL saturate at 255, never wrap.
REQ-027 clr_cnt=1 SHALL zero both counters on the next edge; when coincident with an increment, the clear SHALL take precedence.
REQ-028 lcd_rst_n SHALL be 0 in every state except RUN; pll_reset SHALL be 1 only in PLL_RST.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=WAIT_LOCK, timer=0, pll_reset=0, lcd_rst_n=0, locked=0, loss_cnt=0, retry_cnt=0, synchronizer flops=0.
REQ-030 Reset asserted mid-operation (any state, including PLL_RST) SHALL abort it with no counter increment; operation resumes from WAIT_LOCK on the first edge after release.

Verification (LOCK_FILT=8, RST_HOLD=4, TIMEOUT=32, RESET_PULSE=5)
REQ-031 Release reset with lock_in=1 -> locked=1 at edge 11, lcd_rst_n=1 at edge 15, state=3.
REQ-032 lock_in held 0 -> pll_reset=1 from edge 32 for 5 cycles, retry_cnt=1; second timeout -> retry_cnt=2.
REQ-033 In RUN, drop lock_in for 1 cycle -> lcd_rst_n=0 at edge 3, loss_cnt=1, relock after 8+4 more cycles of lock.
REQ-034 In FILTER, glitch lock_in low at filter count 5 -> return to WAIT_LOCK, loss_cnt unchanged, locked stays 0.
REQ-035 Force 300 losses -> loss_cnt=255; clr_cnt coincident with a loss -> loss_cnt=0.
REQ-036 Assert rst_n=0 during PLL_RST -> pll_reset=0 immediately, retry_cnt=0, state=0.
